// File: rtl/serv_rf_ram_bridge.sv
// SERV register-file bridge: bit-serial rs1/rs2 read streams and two serial write ports
// mapped onto W-bit word accesses of a 1R1W RAM with one-cycle read latency.
module serv_rf_ram_bridge #(
    parameter  int W        = 2,
    parameter  int CSR_REGS = 4,
    localparam int RAW      = $clog2(32 + CSR_REGS),
    localparam int AW       = RAW + $clog2(32 / W)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_rreq,
    input  logic           i_wreq,
    output logic           o_ready,
    input  logic [RAW-1:0] i_rreg0,
    input  logic [RAW-1:0] i_rreg1,
    input  logic [RAW-1:0] i_wreg0,
    input  logic [RAW-1:0] i_wreg1,
    input  logic           i_wen0,
    input  logic           i_wen1,
    input  logic           i_wdata0,
    input  logic           i_wdata1,
    output logic           o_rdata0,
    output logic           o_rdata1,
    output logic [AW-1:0]  o_waddr,
    output logic [W-1:0]   o_wdata,
    output logic           o_wen,
    output logic [AW-1:0]  o_raddr,
    output logic           o_ren,
    input  logic [W-1:0]   i_rdata
);

    localparam int         WB    = $clog2(W);
    localparam int         IB    = 5 - WB;
    localparam logic [4:0] LAST  = 5'(W - 1);
    localparam logic [4:0] PRE   = 5'(W - 2);

    typedef enum logic [1:0] {IDLE, PRE0, PRE1, STREAM} state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           rd_q, rd_d;
    logic [W-1:0]   rbuf0_q, rbuf1_q;
    logic [W-1:0]   wbuf0_q, wbuf1_q;
    logic           wok0_q, wok1_q;
    logic           wen_q, p1_pend_q;
    logic [AW-1:0]  waddr_q, p1_addr_q;
    logic [W-1:0]   wdata_q, p1_data_q;

    function automatic logic [AW-1:0] word_addr(input logic [RAW-1:0] r, input logic [5:0] n);
        return (AW'(r) << IB) | AW'(n);
    endfunction

    logic         stream, word_end, bypass, ok0, ok1;
    logic [4:0]   k_mod;
    logic [5:0]   k6, nxt1, nxt2;
    logic [W-1:0] wnew0, wnew1;

    assign stream   = (state_q == STREAM);
    assign k_mod    = cnt_q & LAST;
    assign k6       = {1'b0, cnt_q};
    assign nxt1     = k6 + 6'd1;
    assign nxt2     = k6 + 6'd2;
    assign word_end = stream && (k_mod == LAST);
    // The rs2 word for slot n arrives in the very cycle its first bit is due.
    assign bypass   = stream && (k_mod == 5'd0) && (cnt_q != 5'd0);
    assign wnew0    = {i_wdata0, wbuf0_q[W-1:1]};
    assign wnew1    = {i_wdata1, wbuf1_q[W-1:1]};
    assign ok0      = ((k_mod == 5'd0) | wok0_q) & i_wen0;
    assign ok1      = ((k_mod == 5'd0) | wok1_q) & i_wen1;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: if (i_rreq || i_wreq) begin
                state_d = PRE0;
                rd_d    = i_rreq;
            end
            PRE0:   state_d = PRE1;
            PRE1: begin
                state_d = STREAM;
                cnt_d   = '0;
            end
            STREAM: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ren   = 1'b0;
        o_raddr = '0;
        if (!i_rst) begin
            case (state_q)
                IDLE: if (i_rreq) begin
                    o_ren   = 1'b1;
                    o_raddr = word_addr(i_rreg0, 6'd0);
                end
                PRE0: if (rd_q) begin
                    o_ren   = 1'b1;
                    o_raddr = word_addr(i_rreg1, 6'd0);
                end
                STREAM: if (rd_q) begin
                    if (k_mod == PRE && nxt2 < 6'd32) begin
                        o_ren   = 1'b1;
                        o_raddr = word_addr(i_rreg0, nxt2 >> WB);
                    end else if (k_mod == LAST && nxt1 < 6'd32) begin
                        o_ren   = 1'b1;
                        o_raddr = word_addr(i_rreg1, nxt1 >> WB);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wen_q     <= 1'b0;
            p1_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            if (word_end) begin
                wen_q     <= ok0 & (|i_wreg0);
                p1_pend_q <= ok1 & (|i_wreg1);
            end else begin
                wen_q     <= p1_pend_q;
                p1_pend_q <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers are not reset; every use is qualified by reset-cleared control.
    always_ff @(posedge i_clk) begin
        case (state_q)
            PRE0: rbuf0_q <= i_rdata;
            PRE1: rbuf1_q <= i_rdata;
            STREAM: begin
                rbuf0_q <= (k_mod == LAST) ? i_rdata : (rbuf0_q >> 1);
                rbuf1_q <= bypass ? (i_rdata >> 1) : (rbuf1_q >> 1);
            end
            default: ;
        endcase
        if (stream) begin
            if (i_wen0) wbuf0_q <= wnew0;
            if (i_wen1) wbuf1_q <= wnew1;
            wok0_q <= ok0;
            wok1_q <= ok1;
        end
        if (word_end) begin
            waddr_q   <= word_addr(i_wreg0, k6 >> WB);
            wdata_q   <= wnew0;
            p1_addr_q <= word_addr(i_wreg1, k6 >> WB);
            p1_data_q <= wnew1;
        end else if (p1_pend_q) begin
            waddr_q <= p1_addr_q;
            wdata_q <= p1_data_q;
        end
    end

    assign o_ready  = (state_q == PRE1);
    assign o_rdata0 = stream && rd_q && (|i_rreg0) && rbuf0_q[0];
    assign o_rdata1 = stream && rd_q && (|i_rreg1) && (bypass ? i_rdata[0] : rbuf1_q[0]);
    assign o_wen    = wen_q;
    assign o_waddr  = waddr_q;
    assign o_wdata  = wdata_q;

endmodule
